// File: rtl/rv32i_pkg.sv
// Shared RV32I write-back types: load funct3 encodings and the write-back entry record.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        is_load;
    } wb_entry_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Write-back stage signal bundle: execute/load handshakes, scoreboard queries, RF write port.
interface writeback_unit_if;

    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;

    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_byte_off;
    logic [31:0] ld_rdata;

    logic        sb_set;
    logic [4:0]  sb_rd;
    logic        sb_busy;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_hazard;
    logic        rs2_hazard;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    modport master (
        output ex_valid, ex_rd, ex_result,
        output ld_valid, ld_rd, ld_funct3, ld_byte_off, ld_rdata,
        output sb_set, sb_rd, rs1_addr, rs2_addr,
        input  ex_ready, ld_ready, sb_busy, rs1_hazard, rs2_hazard,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  ex_valid, ex_rd, ex_result,
        input  ld_valid, ld_rd, ld_funct3, ld_byte_off, ld_rdata,
        input  sb_set, sb_rd, rs1_addr, rs2_addr,
        output ex_ready, ld_ready, sb_busy, rs1_hazard, rs2_hazard,
        output rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a load word and sign- or zero-extends it.
module load_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[7:0];
        case (byte_off)
            2'd0: sel_byte = rdata[7:0];
            2'd1: sel_byte = rdata[15:8];
            2'd2: sel_byte = rdata[23:16];
            2'd3: sel_byte = rdata[31:24];
            default: sel_byte = rdata[7:0];
        endcase
        // Halfword accesses only look at the upper offset bit; misalignment is not trapped here.
        sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  data = {24'b0, sel_byte};
            F3_LH:   data = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  data = {16'b0, sel_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: arbitrates execute results against buffered load responses into the
// registered RF write port and tracks pending loads per register for decode stalls.
module writeback_unit
    import rv32i_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int SB_CNT_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    writeback_unit_if.slave  wb
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [SB_CNT_W-1:0] SB_MAX = '1;

    wb_entry_t             fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           fifo_cnt;
    logic                  full;
    logic                  empty;
    logic                  ex_fire;
    logic                  ld_fire;
    logic                  deq;
    logic [31:0]           ld_data;
    wb_entry_t             win;
    logic                  win_valid;
    logic                  rf_is_load;
    logic [SB_CNT_W-1:0]   sb_cnt [32];
    logic                  sb_inc;
    logic                  sb_dec;
    logic [31:0]           inc_vec;
    logic [31:0]           dec_vec;

    load_align u_load_align (
        .funct3   (wb.ld_funct3),
        .byte_off (wb.ld_byte_off),
        .rdata    (wb.ld_rdata),
        .data     (ld_data)
    );

    assign full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign empty = (fifo_cnt == '0);

    assign wb.ex_ready = !full && !rst;
    assign wb.ld_ready = !full && !rst;

    assign ex_fire = wb.ex_valid && wb.ex_ready;
    assign ld_fire = wb.ld_valid && wb.ld_ready;
    // A full buffer blocks execute, so the head drains whenever execute is not taking the port.
    assign deq     = !empty && !ex_fire;

    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        if (ex_fire) begin
            win       = '{rd: wb.ex_rd, data: wb.ex_result, is_load: 1'b0};
            win_valid = 1'b1;
        end else if (deq) begin
            win       = fifo_mem[rd_ptr];
            win_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (ld_fire) begin
                fifo_mem[wr_ptr] <= '{rd: wb.ld_rd, data: ld_data, is_load: 1'b1};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ld_fire && !deq) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (!ld_fire && deq) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb.rf_we    <= 1'b0;
            wb.rf_waddr <= '0;
            wb.rf_wdata <= '0;
            rf_is_load  <= 1'b0;
        end else begin
            wb.rf_we <= win_valid && (win.rd != 5'd0);
            if (win_valid) begin
                wb.rf_waddr <= win.rd;
                wb.rf_wdata <= win.data;
                rf_is_load  <= win.is_load;
            end
        end
    end

    assign wb.sb_busy = (sb_cnt[wb.sb_rd] == SB_MAX);
    assign sb_inc     = wb.sb_set && !wb.sb_busy && (wb.sb_rd != 5'd0);
    // The count drops when the register file actually commits the load, not when it is presented.
    assign sb_dec     = wb.rf_we && rf_is_load;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (sb_inc) inc_vec[wb.sb_rd]    = 1'b1;
        if (sb_dec) dec_vec[wb.rf_waddr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (rst) begin
                sb_cnt[i] <= '0;
            end else if (inc_vec[i] && !dec_vec[i]) begin
                sb_cnt[i] <= sb_cnt[i] + 1'b1;
            end else if (dec_vec[i] && !inc_vec[i] && (sb_cnt[i] != '0)) begin
                sb_cnt[i] <= sb_cnt[i] - 1'b1;
            end
        end
    end

    assign wb.rs1_hazard = (wb.rs1_addr != 5'd0) && (sb_cnt[wb.rs1_addr] != '0);
    assign wb.rs2_hazard = (wb.rs2_addr != 5'd0) && (sb_cnt[wb.rs2_addr] != '0);

endmodule
